clk_en_gen: RTL and testbench

- Parametrised, multi-channel fractional clock-enable generator. It is the single-clock successor to the fixed two-output PLL wrapper.
- Runs in the fast system clock domain and produces NUM_CH independent single-cycle enable strobes, each at a runtime-programmable average rate refclk*num/den.
- Core sub-blocks (CPU, sound, video pixel) derive their rates from it instead of from extra PLL outputs.
- Adds a lock/settling window, phase-aligned restart, pause and runtime reprogramming, none of which a hard PLL output provides.

---
 rtl/clk_en_pkg.sv | 14 +
 rtl/clk_en_chan.sv | 70 +++++++
 rtl/clk_en_gen.sv | 79 +++++++
 tb/tb_clk_en_gen.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clk_en_pkg.sv
// Shared defaults and types for the fractional clock-enable generator.
package clk_en_pkg;

   localparam int unsigned NUM_CH_DEF      = 4;
   localparam int unsigned ACC_W_DEF       = 16;
   localparam int unsigned LOCK_CYCLES_DEF = 256;

   // Channel ratio record at the default accumulator width.
   typedef struct packed {
      logic [ACC_W_DEF-1:0] num;
      logic [ACC_W_DEF-1:0] den;
   } ratio_t;

endpackage

// File: rtl/clk_en_chan.sv
// One fractional enable channel: ratio registers, phase accumulator, ce flop.
module clk_en_chan
   import clk_en_pkg::*;
#(
   parameter int unsigned ACC_W = ACC_W_DEF
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             wr_i,
   input  logic [ACC_W-1:0] num_i,
   input  logic [ACC_W-1:0] den_i,
   input  logic             clr_i,
   input  logic             hold_i,
   output logic             ce_o
);

   typedef struct packed {
      logic [ACC_W-1:0] num;
      logic [ACC_W-1:0] den;
   } chan_ratio_t;

   chan_ratio_t      ratio_q, ratio_d;
   logic [ACC_W-1:0] acc_q, acc_d;
   logic             ce_q, ce_d;
   logic [ACC_W:0]   sum;
   logic [ACC_W:0]   diff;

   // Next accumulator / strobe; a config write overrides the run/hold/clear decision.
   always_comb begin
      ratio_d = ratio_q;
      acc_d   = acc_q;
      ce_d    = 1'b0;
      sum     = {1'b0, acc_q} + {1'b0, ratio_q.num};
      diff    = sum - {1'b0, ratio_q.den};
      if (clr_i) begin
         acc_d = '0;
      end else if (hold_i) begin
         acc_d = acc_q;
      end else if (ratio_q.den == '0) begin
         acc_d = '0;
      end else if (sum >= {1'b0, ratio_q.den}) begin
         acc_d = diff[ACC_W-1:0];
         ce_d  = 1'b1;
      end else begin
         acc_d = sum[ACC_W-1:0];
      end
      if (wr_i) begin
         ratio_d.num = (num_i > den_i) ? den_i : num_i;
         ratio_d.den = den_i;
         acc_d       = '0;
         ce_d        = 1'b0;
      end
   end

   // Channel state registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         ratio_q <= '0;
         acc_q   <= '0;
         ce_q    <= 1'b0;
      end else begin
         ratio_q <= ratio_d;
         acc_q   <= acc_d;
         ce_q    <= ce_d;
      end
   end

   assign ce_o = ce_q;

endmodule

// File: rtl/clk_en_gen.sv
// Multi-channel fractional clock-enable generator with lock window, sync and pause.
module clk_en_gen
   import clk_en_pkg::*;
#(
   parameter int unsigned NUM_CH      = NUM_CH_DEF,
   parameter int unsigned ACC_W       = ACC_W_DEF,
   parameter int unsigned LOCK_CYCLES = LOCK_CYCLES_DEF
) (
   input  logic                                           refclk,
   input  logic                                           rst_n,
   input  logic                                           cfg_we,
   input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] cfg_ch,
   input  logic [ACC_W-1:0]                               cfg_num,
   input  logic [ACC_W-1:0]                               cfg_den,
   input  logic                                           sync,
   input  logic                                           pause,
   output logic [NUM_CH-1:0]                              ce,
   output logic                                           locked,
   output logic                                           cfg_err
);

   localparam int unsigned LW = $clog2(LOCK_CYCLES + 1);
   localparam logic [LW-1:0] LOCK_MAX = LW'(LOCK_CYCLES);

   logic [LW-1:0] cnt_q, cnt_d;
   logic          locked_q, locked_d;
   logic          cfg_err_q, cfg_err_d;
   logic          cfg_valid;
   logic          clr;

   assign cfg_valid = cfg_we && (32'(cfg_ch) < NUM_CH);
   // Accumulators stay cleared until settled so every channel starts in phase.
   assign clr = !locked_q || sync;

   // Lock counter and sticky ratio error; a valid write restarts settling.
   always_comb begin
      cnt_d     = cnt_q;
      locked_d  = locked_q;
      cfg_err_d = cfg_err_q;
      if (cfg_valid) begin
         cnt_d    = '0;
         locked_d = 1'b0;
         if (cfg_num > cfg_den) cfg_err_d = 1'b1;
      end else if (cnt_q < LOCK_MAX) begin
         cnt_d    = cnt_q + LW'(1);
         locked_d = (cnt_d == LOCK_MAX);
      end
   end

   // Lock / error registers.
   always_ff @(posedge refclk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q     <= '0;
         locked_q  <= 1'b0;
         cfg_err_q <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         locked_q  <= locked_d;
         cfg_err_q <= cfg_err_d;
      end
   end

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      clk_en_chan #(.ACC_W(ACC_W)) u_chan (
         .clk_i  (refclk),
         .rst_ni (rst_n),
         .wr_i   (cfg_valid && (32'(cfg_ch) == g)),
         .num_i  (cfg_num),
         .den_i  (cfg_den),
         .clr_i  (clr),
         .hold_i (pause),
         .ce_o   (ce[g])
      );
   end

   assign locked  = locked_q;
   assign cfg_err = cfg_err_q;

endmodule

// File: tb/tb_clk_en_gen.sv
// Directed self-checking bench for clk_en_gen (5 channels so cfg_ch=NUM_CH is drivable).
module tb_clk_en_gen;
   import clk_en_pkg::*;

   localparam int unsigned NCH = 5;

   logic        refclk = 1'b0;
   logic        rst_n;
   logic        cfg_we;
   logic [2:0]  cfg_ch;
   logic [15:0] cfg_num;
   logic [15:0] cfg_den;
   logic        sync;
   logic        pause;
   logic [4:0]  ce;
   logic        locked;
   logic        cfg_err;

   int checks = 0;
   int errors = 0;

   // Hand-derived expectation state: edges run since the last phase alignment.
   int         run_n   = 0;
   int         ch0_div = 0;
   bit         ch2_on  = 0;
   bit         ch3_on  = 0;
   logic [7:0] pat_v   = 8'b1010_0100; // 3/8 pattern, bit i = cycle i: 0,0,1,0,0,1,0,1

   clk_en_gen #(.NUM_CH(NCH), .ACC_W(16), .LOCK_CYCLES(256)) dut (
      .refclk  (refclk),
      .rst_n   (rst_n),
      .cfg_we  (cfg_we),
      .cfg_ch  (cfg_ch),
      .cfg_num (cfg_num),
      .cfg_den (cfg_den),
      .sync    (sync),
      .pause   (pause),
      .ce      (ce),
      .locked  (locked),
      .cfg_err (cfg_err)
   );

   always #5 refclk = ~refclk;

   task automatic tick();
      @(posedge refclk);
      #1;
   endtask

   function automatic logic [4:0] exp_ce(int n);
      logic [4:0] e;
      e    = '0;
      e[0] = (ch0_div != 0) && ((n % ch0_div) == 0);
      e[1] = 1'b1;
      e[2] = ch2_on && pat_v[(n - 1) % 8];
      e[3] = ch3_on;
      return e;
   endfunction

   task automatic cfg_write(input logic [2:0] ch, input ratio_t r);
      cfg_ch  = ch;
      cfg_num = r.num;
      cfg_den = r.den;
      cfg_we  = 1'b1;
      tick();
      cfg_we  = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; cfg_we = 1'b0; cfg_ch = '0; cfg_num = '0; cfg_den = '0;
      sync = 1'b0; pause = 1'b0;
      repeat (3) tick();
      checks++;
      if ({ce, locked, cfg_err} !== 7'b0) begin
         errors++;
         $display("FAIL reset_outputs: got ce=%b locked=%b cfg_err=%b, want all 0", ce, locked, cfg_err);
      end
      rst_n = 1'b1;
      for (int e = 1; e <= 256; e++) begin
         tick();
         checks++;
         if (locked !== (e == 256) || ce !== 5'b0) begin
            errors++;
            $display("FAIL reset_lock edge %0d: got locked=%b ce=%b, want locked=%b ce=0", e, locked, ce, (e == 256));
         end
      end
   endtask

   task automatic test_ratio();
      cfg_write(3'd0, '{num: 16'd1, den: 16'd4});
      cfg_write(3'd1, '{num: 16'd4, den: 16'd4});
      ch0_div = 4;
      for (int k = 1; k <= 256; k++) begin
         tick();
         checks++;
         if (locked !== (k == 256) || ce !== 5'b0) begin
            errors++;
            $display("FAIL ratio_lock k=%0d: got locked=%b ce=%b, want locked=%b ce=0", k, locked, ce, (k == 256));
         end
      end
      run_n = 0;
      for (int j = 1; j <= 16; j++) begin
         tick(); run_n++;
         checks++;
         if (ce !== exp_ce(run_n)) begin
            errors++;
            $display("FAIL ratio_ce n=%0d: got %b, want %b", run_n, ce, exp_ce(run_n));
         end
      end
   endtask

   task automatic test_frac();
      int pulses;
      cfg_write(3'd2, '{num: 16'd3, den: 16'd8});
      ch2_on = 1;
      for (int k = 1; k <= 256; k++) begin
         tick();
         checks++;
         if (locked !== (k == 256) || ce !== 5'b0) begin
            errors++;
            $display("FAIL frac_lock k=%0d: got locked=%b ce=%b, want locked=%b ce=0", k, locked, ce, (k == 256));
         end
      end
      run_n  = 0;
      pulses = 0;
      for (int j = 1; j <= 800; j++) begin
         tick(); run_n++;
         if (ce[2] === 1'b1) pulses++;
         checks++;
         if (ce !== exp_ce(run_n)) begin
            errors++;
            $display("FAIL frac_ce n=%0d: got %b, want %b", run_n, ce, exp_ce(run_n));
         end
      end
      checks++;
      if (pulses != 300) begin
         errors++;
         $display("FAIL frac_count: got %0d pulses, want 300", pulses);
      end
   endtask

   task automatic test_reprogram();
      for (int j = 1; j <= 3; j++) begin
         tick(); run_n++;
         checks++;
         if (ce !== exp_ce(run_n)) begin
            errors++;
            $display("FAIL reprog_pre n=%0d: got %b, want %b", run_n, ce, exp_ce(run_n));
         end
      end
      cfg_write(3'd0, '{num: 16'd1, den: 16'd2});
      ch0_div = 2;
      checks++;
      if (locked !== 1'b0) begin
         errors++;
         $display("FAIL reprog_drop: got locked=%b, want 0", locked);
      end
      for (int k = 1; k <= 256; k++) begin
         tick();
         checks++;
         if (locked !== (k == 256) || ce !== 5'b0) begin
            errors++;
            $display("FAIL reprog_lock k=%0d: got locked=%b ce=%b, want locked=%b ce=0", k, locked, ce, (k == 256));
         end
      end
      run_n = 0;
      for (int j = 1; j <= 16; j++) begin
         tick(); run_n++;
         checks++;
         if (ce !== exp_ce(run_n)) begin
            errors++;
            $display("FAIL reprog_ce n=%0d: got %b, want %b", run_n, ce, exp_ce(run_n));
         end
      end
   endtask

   task automatic test_pause_sync();
      for (int j = 1; j <= 3; j++) begin
         tick(); run_n++;
         checks++;
         if (ce !== exp_ce(run_n)) begin
            errors++;
            $display("FAIL pre_pause n=%0d: got %b, want %b", run_n, ce, exp_ce(run_n));
         end
      end
      pause = 1'b1;
      for (int j = 1; j <= 10; j++) begin
         tick();
         checks++;
         if (ce !== 5'b0 || locked !== 1'b1) begin
            errors++;
            $display("FAIL pause j=%0d: got ce=%b locked=%b, want ce=0 locked=1", j, ce, locked);
         end
      end
      pause = 1'b0;
      for (int j = 1; j <= 8; j++) begin
         tick(); run_n++;
         checks++;
         if (ce !== exp_ce(run_n)) begin
            errors++;
            $display("FAIL resume n=%0d: got %b, want %b", run_n, ce, exp_ce(run_n));
         end
      end
      sync = 1'b1;
      tick();
      sync = 1'b0;
      checks++;
      if (ce !== 5'b0 || locked !== 1'b1) begin
         errors++;
         $display("FAIL sync_edge: got ce=%b locked=%b, want ce=0 locked=1", ce, locked);
      end
      run_n = 0;
      for (int j = 1; j <= 16; j++) begin
         tick(); run_n++;
         checks++;
         if (ce !== exp_ce(run_n)) begin
            errors++;
            $display("FAIL post_sync n=%0d: got %b, want %b", run_n, ce, exp_ce(run_n));
         end
      end
   endtask

   task automatic test_clamp_oob();
      checks++;
      if (cfg_err !== 1'b0) begin
         errors++;
         $display("FAIL err_before: got cfg_err=%b, want 0", cfg_err);
      end
      cfg_write(3'd3, '{num: 16'd5, den: 16'd3});
      ch3_on = 1;
      checks++;
      if (cfg_err !== 1'b1) begin
         errors++;
         $display("FAIL err_set: got cfg_err=%b, want 1", cfg_err);
      end
      for (int k = 1; k <= 256; k++) begin
         tick();
         checks++;
         if (locked !== (k == 256) || ce !== 5'b0) begin
            errors++;
            $display("FAIL clamp_lock k=%0d: got locked=%b ce=%b, want locked=%b ce=0", k, locked, ce, (k == 256));
         end
      end
      run_n = 0;
      for (int j = 1; j <= 8; j++) begin
         tick(); run_n++;
         checks++;
         if (ce !== exp_ce(run_n) || cfg_err !== 1'b1) begin
            errors++;
            $display("FAIL clamp_ce n=%0d: got ce=%b err=%b, want ce=%b err=1", run_n, ce, cfg_err, exp_ce(run_n));
         end
      end
      cfg_write(3'd5, '{num: 16'd1, den: 16'd1});
      run_n++;
      checks++;
      if (locked !== 1'b1 || ce !== exp_ce(run_n)) begin
         errors++;
         $display("FAIL oob_write: got locked=%b ce=%b, want locked=1 ce=%b", locked, ce, exp_ce(run_n));
      end
      for (int j = 1; j <= 8; j++) begin
         tick(); run_n++;
         checks++;
         if (ce !== exp_ce(run_n) || locked !== 1'b1) begin
            errors++;
            $display("FAIL oob_after n=%0d: got ce=%b locked=%b, want ce=%b locked=1", run_n, ce, locked, exp_ce(run_n));
         end
      end
   endtask

   task automatic test_async_reset();
      tick(); run_n++;
      checks++;
      if (ce !== exp_ce(run_n)) begin
         errors++;
         $display("FAIL pre_reset n=%0d: got %b, want %b", run_n, ce, exp_ce(run_n));
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if (ce !== 5'b0 || locked !== 1'b0 || cfg_err !== 1'b0) begin
         errors++;
         $display("FAIL async_reset: got ce=%b locked=%b cfg_err=%b, want all 0", ce, locked, cfg_err);
      end
      tick();
   endtask

   initial begin
      test_reset();
      test_ratio();
      test_frac();
      test_reprogram();
      test_pause_sync();
      test_clamp_oob();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
